// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the programmable tick generator.
package tick_gen_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  localparam int DEF_PERIOD_1S = 20_000_000;

  // A single channel still needs a 1-bit index so the port never collapses to zero width.
  function automatic int ch_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: counter, active/shadow period and mode, run flag, tick pulse and square wave.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int PERIOD_W   = 27,
  parameter int DEF_PERIOD = DEF_PERIOD_1S,
  parameter bit AUTO_START = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_oneshot,
  input  logic                start,
  input  logic                stop,
  output logic                tick,
  output logic                sq,
  output logic                running
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] act_period;
  logic [PERIOD_W-1:0] shadow_period;
  mode_e               act_mode;
  mode_e               shadow_mode;

  logic [PERIOD_W-1:0] last_cnt;
  logic [PERIOD_W-1:0] next_period;
  mode_e               next_mode;
  logic                wrap;

  // A write landing on a start/wrap edge bypasses the shadow so it takes effect immediately.
  always_comb begin
    last_cnt    = (act_period == '0) ? '0 : act_period - PERIOD_W'(1);
    next_period = cfg_we ? cfg_period : shadow_period;
    next_mode   = cfg_we ? mode_e'(cfg_oneshot) : shadow_mode;
    wrap        = running && (cnt == last_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      tick          <= 1'b0;
      sq            <= 1'b0;
      running       <= AUTO_START;
      act_period    <= PERIOD_W'(DEF_PERIOD);
      shadow_period <= PERIOD_W'(DEF_PERIOD);
      act_mode      <= MODE_PERIODIC;
      shadow_mode   <= MODE_PERIODIC;
    end else begin
      if (cfg_we) begin
        shadow_period <= cfg_period;
        shadow_mode   <= mode_e'(cfg_oneshot);
      end

      // Priority: stop, then start/restart, then the normal count/wrap.
      if (stop) begin
        running <= 1'b0;
        cnt     <= '0;
        tick    <= 1'b0;
      end else if (start) begin
        running    <= 1'b1;
        cnt        <= '0;
        tick       <= 1'b0;
        act_period <= next_period;
        act_mode   <= next_mode;
      end else if (wrap) begin
        cnt        <= '0;
        tick       <= 1'b1;
        sq         <= ~sq;
        act_period <= next_period;
        act_mode   <= next_mode;
        if (act_mode == MODE_ONESHOT) begin
          running <= 1'b0;
        end
      end else if (running) begin
        cnt  <= cnt + PERIOD_W'(1);
        tick <= 1'b0;
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tick_generator.sv
// Multi-channel programmable tick/enable generator; the top only decodes config writes per channel.
module tick_generator
  import tick_gen_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int PERIOD_W   = 27,
  parameter int DEF_PERIOD = DEF_PERIOD_1S,
  parameter int AUTO_START = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [ch_idx_width(N_CH)-1:0]  cfg_ch,
  input  logic [PERIOD_W-1:0]            cfg_period,
  input  logic                           cfg_oneshot,
  input  logic [N_CH-1:0]                start,
  input  logic [N_CH-1:0]                stop,
  output logic [N_CH-1:0]                tick,
  output logic [N_CH-1:0]                sq,
  output logic [N_CH-1:0]                running
);

  localparam int CH_W = ch_idx_width(N_CH);

  logic [N_CH-1:0] chan_we;

  // Indices >= N_CH match no channel, so such writes are silently dropped.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    assign chan_we[gi] = cfg_we && (cfg_ch == CH_W'(gi));

    tick_chan #(
      .PERIOD_W   (PERIOD_W),
      .DEF_PERIOD (DEF_PERIOD),
      .AUTO_START (AUTO_START != 0)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (chan_we[gi]),
      .cfg_period  (cfg_period),
      .cfg_oneshot (cfg_oneshot),
      .start       (start[gi]),
      .stop        (stop[gi]),
      .tick        (tick[gi]),
      .sq          (sq[gi]),
      .running     (running[gi])
    );
  end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator: 3 channels, 8-bit periods, reset period 5.
module tb_tick_generator;

  localparam int N_CH     = 3;
  localparam int PERIOD_W = 8;

  logic                clk         = 1'b0;
  logic                rst         = 1'b1;
  logic                cfg_we      = 1'b0;
  logic [1:0]          cfg_ch      = '0;
  logic [PERIOD_W-1:0] cfg_period  = '0;
  logic                cfg_oneshot = 1'b0;
  logic [N_CH-1:0]     start       = '0;
  logic [N_CH-1:0]     stop        = '0;
  logic [N_CH-1:0]     tick;
  logic [N_CH-1:0]     sq;
  logic [N_CH-1:0]     running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_generator #(
    .N_CH       (N_CH),
    .PERIOD_W   (PERIOD_W),
    .DEF_PERIOD (5),
    .AUTO_START (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .stop        (stop),
    .tick        (tick),
    .sq          (sq),
    .running     (running)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [PERIOD_W-1:0] p, input logic os);
    cfg_we      = 1'b1;
    cfg_ch      = ch;
    cfg_period  = p;
    cfg_oneshot = os;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [N_CH-1:0] m);
    start = m;
    cyc();
    start = '0;
  endtask

  initial begin
    int n;
    logic [N_CH-1:0] acc;
    logic [N_CH-1:0] acc_run;

    // 1: reset state, idle for 50 cycles
    cyc();
    cyc();
    check_val("rst_running", running, 3'b000);
    check_val("rst_tick", tick, 3'b000);
    check_val("rst_sq", sq, 3'b000);
    rst = 1'b0;
    acc = '0;
    acc_run = '0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      acc |= tick;
      acc_run |= running;
    end
    check_val("idle_no_tick", acc, 3'b000);
    check_val("idle_running", acc_run, 3'b000);
    check_val("idle_sq", sq, 3'b000);

    // 2: ch0 periodic P=5, ticks after E5, E10, E15
    write_cfg(2'd0, 8'd5, 1'b0);
    pulse_start(3'b001);
    check_val("p5_start_running", running, 3'b001);
    check_val("p5_start_tick", tick, 3'b000);
    n = 0;
    acc = '0;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      n += int'(tick[0]);
      acc |= tick & 3'b110;
      if (i == 4) check_val("p5_e4_tick", tick[0], 1'b0);
      if (i == 5) begin
        check_val("p5_e5_tick", tick[0], 1'b1);
        check_val("p5_e5_sq", sq[0], 1'b1);
      end
      if (i == 6) check_val("p5_e6_tick", tick[0], 1'b0);
      if (i == 10) check_val("p5_e10_sq", sq[0], 1'b0);
      if (i == 15) check_val("p5_e15_sq", sq[0], 1'b1);
    end
    check_val("p5_tick_count", n, 3);
    check_val("p5_others_idle", acc, 3'b000);

    // 4: write P=2 mid-period, then P=3 exactly on a wrap edge
    cyc();                              // E16, cnt=1
    write_cfg(2'd0, 8'd2, 1'b0);        // E17
    cyc();                              // E18
    cyc();                              // E19
    check_val("shadow_e19_tick", tick[0], 1'b0);
    cyc();                              // E20: still 5-cycle spacing
    check_val("shadow_e20_tick", tick[0], 1'b1);
    cyc();
    check_val("shadow_e21_tick", tick[0], 1'b0);
    cyc();                              // E22: now period 2
    check_val("shadow_e22_tick", tick[0], 1'b1);
    cyc();                              // E23
    write_cfg(2'd0, 8'd3, 1'b0);        // E24: wrap and write together
    check_val("bypass_e24_tick", tick[0], 1'b1);
    cyc();
    cyc();                              // E26
    check_val("bypass_e26_tick", tick[0], 1'b0);
    cyc();                              // E27
    check_val("bypass_e27_tick", tick[0], 1'b1);
    stop = 3'b001;
    cyc();
    stop = '0;
    check_val("stop_running", running[0], 1'b0);
    check_val("stop_tick", tick[0], 1'b0);
    check_val("stop_sq_held", sq[0], 1'b1);

    // 3: ch1 one-shot P=3; write to non-existent channel 3 must be ignored
    write_cfg(2'd1, 8'd3, 1'b1);
    write_cfg(2'd3, 8'd1, 1'b0);
    pulse_start(3'b010);
    check_val("os_start_running", running[1], 1'b1);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      n += int'(tick[1]);
      if (i == 2) begin
        check_val("os_e2_tick", tick[1], 1'b0);
        check_val("os_e2_running", running[1], 1'b1);
      end
      if (i == 3) begin
        check_val("os_e3_tick", tick[1], 1'b1);
        check_val("os_e3_running", running[1], 1'b0);
      end
    end
    check_val("os_tick_count", n, 1);
    check_val("os_end_running", running[1], 1'b0);

    // 5: P=0 and P=1 hold tick high; start+stop together stays stopped
    write_cfg(2'd2, 8'd0, 1'b0);
    pulse_start(3'b100);
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      n += int'(tick[2]);
    end
    check_val("p0_tick_count", n, 6);
    check_val("p0_sq", sq[2], 1'b0);
    stop = 3'b100;
    cyc();
    stop = '0;
    check_val("p0_stop_tick", tick[2], 1'b0);
    cfg_we     = 1'b1;
    cfg_ch     = 2'd2;
    cfg_period = 8'd1;
    start      = 3'b100;
    cyc();
    cfg_we = 1'b0;
    start  = '0;
    check_val("p1_start_tick", tick[2], 1'b0);
    n = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n += int'(tick[2]);
    end
    check_val("p1_tick_count", n, 4);
    check_val("p1_sq", sq[2], 1'b0);
    start = 3'b100;
    stop  = 3'b100;
    cyc();
    start = '0;
    stop  = '0;
    check_val("startstop_running", running[2], 1'b0);
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      acc |= tick & 3'b100;
    end
    check_val("startstop_no_tick", acc, 3'b000);

    // 6: restart at cnt=4 suppresses the tick; reset mid-count restores defaults
    write_cfg(2'd0, 8'd5, 1'b0);
    pulse_start(3'b001);                // E0
    for (int i = 0; i < 4; i++) cyc();  // E1..E4, cnt=4
    pulse_start(3'b001);                // E5 restart
    check_val("restart_tick", tick[0], 1'b0);
    check_val("restart_running", running[0], 1'b1);
    check_val("restart_sq_held", sq[0], 1'b1);
    for (int i = 0; i < 4; i++) cyc();  // E6..E9
    check_val("restart_e9_tick", tick[0], 1'b0);
    cyc();                              // E10
    check_val("restart_e10_tick", tick[0], 1'b1);
    check_val("restart_e10_sq", sq[0], 1'b0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_val("midrst_tick", tick, 3'b000);
    check_val("midrst_sq", sq, 3'b000);
    check_val("midrst_running", running, 3'b000);
    pulse_start(3'b010);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 4) check_val("def_e4_tick", tick[1], 1'b0);
      if (i == 5) begin
        check_val("def_e5_tick", tick[1], 1'b1);
        check_val("def_e5_running", running[1], 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
